mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data and address width in bits.
REQ-002 SHALL have parameter ADDR_SIZE, default 10, word-address bits decoded (depth 2**ADDR_SIZE words).
REQ-003 SHALL have parameter WAIT, default 1, wait states per transfer; legal range 0..15.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  1  initiator transfer request.
REQ-007 SHALL have port wen  input  1  1 = write, 0 = read; sampled with req.
REQ-008 SHALL have port addr  input  WIDTH  word address; only bits [ADDR_SIZE-1:0] used.
REQ-009 SHALL have port wdata  input  WIDTH  write data.
REQ-010 SHALL have port rdata  output  WIDTH  registered read data.
REQ-011 SHALL have port ack  output  1  one-cycle transfer-complete strobe.
REQ-012 SHALL have port busy  output  1  high while a transfer is accepted and not yet acked.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, WAITS, ACK.
REQ-014 In IDLE, a rising edge sampling req=1 SHALL accept the transfer: latch addr[ADDR_SIZE-1:0], wen and wdata into internal registers.
REQ-015 On accept, the FSM SHALL go to WAITS with counter loaded to WAIT-1 if WAIT>0, else directly to ACK.
REQ-016 In WAITS, the counter SHALL decrement each cycle; the edge at which counter=0 SHALL move the FSM to ACK.
REQ-017 ack SHALL be 1 exactly in ACK state, for one cycle; ACK SHALL always return to IDLE on the next edge.
REQ-018 ack latency SHALL be WAIT+1 cycles after the accepting edge (WAIT=0: ack in the cycle right after acceptance).
REQ-019 On the edge entering ACK for a read, rdata SHALL load mem[latched addr]; rdata SHALL be valid while ack=1 and hold until the next read enters ACK.
REQ-020 On the edge entering ACK for a write, mem[latched addr] SHALL load latched wdata; rdata SHALL be unchanged.
REQ-021 A read following a write to the same address SHALL return the written data.
REQ-022 req, addr, wen and wdata SHALL be ignored in WAITS and ACK; deasserting req after acceptance SHALL NOT abort the transfer.
REQ-023 A req held high through ACK SHALL be accepted as a new transfer on the first IDLE edge (minimum one idle cycle between transfers).
REQ-024 busy SHALL be 1 in WAITS and ACK, 0 in IDLE.
REQ-025 Address bits above ADDR_SIZE-1 SHALL be ignored; addresses alias modulo 2**ADDR_SIZE.
REQ-026 Memory array SHALL be inferred single-port, one access per transfer.

Reset
REQ-027 reset=0 SHALL immediately force state IDLE, counter 0, ack 0, busy 0, rdata 0, latched registers 0.
REQ-028 Memory contents SHALL NOT be cleared by reset.
REQ-029 Reset asserted before the edge entering ACK SHALL abort the transfer; a pending write SHALL NOT modify memory.
REQ-030 After reset release, the first rising edge with req=1 SHALL be accepted normally.

Verification
REQ-031 WAIT=1: write addr 0x5, wdata 0xDEADBEEF -> ack 2 cycles after accepting edge, busy high 2 cycles; read 0x5 -> rdata 0xDEADBEEF with ack.
REQ-032 WAIT=0: back-to-back reads of 0x1, 0x2 with req held high -> acks in cycles 1 and 3, one idle cycle between, correct data each.
REQ-033 ADDR_SIZE=10: write 0x12345678 to addr 0x405, read addr 0x005 -> rdata 0x12345678 (aliasing).
REQ-034 WAIT=3: accept write to 0x7, drop req next cycle, change addr/wdata -> ack after 4 cycles, mem[0x7] holds original wdata.
REQ-035 WAIT=3: write 0xAAAA5555 to 0x9, then write 0x0 to 0x9 with reset pulsed low during WAITS -> ack never asserts, outputs 0; subsequent read of 0x9 returns 0xAAAA5555.
REQ-036 Read 0x3 (data 0x11) then write 0x4 -> rdata stays 0x11 through write ack.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: single-port word memory behind a req/ack handshake with a
// fixed number of wait states per transfer.
//
// Parameters
//   WIDTH     : data and address width in bits
//   ADDR_SIZE : word-address bits decoded; depth is 2**ADDR_SIZE words
//   WAIT      : wait states per transfer, 0..15
//
// Ports
//   clk   : single clock, all state changes on the rising edge
//   reset : asynchronous, active-low reset
//   req   : transfer request, sampled only while idle
//   wen   : 1 = write, 0 = read; sampled with req
//   addr  : word address; bits above ADDR_SIZE-1 are ignored (aliasing)
//   wdata : write data
//   rdata : registered read data, valid with ack and held until the next read
//   ack   : one-cycle transfer-complete strobe
//   busy  : high from acceptance until (and including) the ack cycle
module mem_responder #(
  parameter int WIDTH     = 32,
  parameter int ADDR_SIZE = 10,
  parameter int WAIT      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             wen,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             ack,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAITS = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam int         DEPTH     = 1 << ADDR_SIZE;
  localparam bit         NO_WAIT   = (WAIT == 0);
  // Counter counts the remaining WAITS cycles after the current one.
  localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  logic [WIDTH-1:0] mem [DEPTH];

  state_t                 state;
  logic [3:0]             cnt;
  logic [ADDR_SIZE-1:0]   addr_lat;
  logic                   wen_lat;
  logic [WIDTH-1:0]       wdata_lat;

  logic                   accept;
  logic                   enter_ack;
  logic [ADDR_SIZE-1:0]   acc_addr;
  logic                   acc_wen;
  logic [WIDTH-1:0]       acc_wdata;
  logic                   mem_we;

  // Upper address bits are deliberately dropped so addresses alias.
  if (WIDTH > ADDR_SIZE) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[WIDTH-1:ADDR_SIZE];
  end

  // With WAIT=0 the access happens on the accepting edge itself, before the
  // latched copies exist, so the access fields come straight from the inputs
  // while idle and from the latched registers otherwise.
  always_comb begin
    accept    = 1'b0;
    enter_ack = 1'b0;
    acc_addr  = addr_lat;
    acc_wen   = wen_lat;
    acc_wdata = wdata_lat;
    mem_we    = 1'b0;

    accept = (state == IDLE) && req;
    if (state == IDLE) begin
      acc_addr  = addr[ADDR_SIZE-1:0];
      acc_wen   = wen;
      acc_wdata = wdata;
    end
    enter_ack = (accept && NO_WAIT) || ((state == WAITS) && (cnt == 4'd0));
    // Gating with reset keeps a write from landing while reset is held low.
    mem_we    = reset && enter_ack && acc_wen;
  end

  // Control, latched request and read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      rdata     <= '0;
      addr_lat  <= '0;
      wen_lat   <= 1'b0;
      wdata_lat <= '0;
    end else begin
      if (enter_ack && !acc_wen) begin
        rdata <= mem[acc_addr];
      end

      case (state)
        IDLE: begin
          ack  <= 1'b0;
          busy <= 1'b0;
          if (accept) begin
            addr_lat  <= addr[ADDR_SIZE-1:0];
            wen_lat   <= wen;
            wdata_lat <= wdata;
            busy      <= 1'b1;
            if (NO_WAIT) begin
              state <= ACK;
              cnt   <= 4'd0;
              ack   <= 1'b1;
            end else begin
              state <= WAITS;
              cnt   <= WAIT_LOAD;
            end
          end
        end

        WAITS: begin
          busy <= 1'b1;
          if (cnt == 4'd0) begin
            state <= ACK;
            ack   <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        ACK: begin
          state <= IDLE;
          ack   <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
          ack   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Memory array: no reset so contents survive reset and a plain single-port
  // RAM can be inferred.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_addr] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder. Three instances with
// WAIT = 1, 0 and 3 (index 0, 1, 2) share one clock and have separate resets.
module tb_mem_responder;

  logic        clk;
  logic [2:0]  rst_n;
  logic [2:0]  req;
  logic [2:0]  wen;
  logic [2:0]  ack;
  logic [2:0]  busy;
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(
      .WIDTH     (32),
      .ADDR_SIZE (10),
      .WAIT      ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk   (clk),
      .reset (rst_n[g]),
      .req   (req[g]),
      .wen   (wen[g]),
      .addr  (addr[g]),
      .wdata (wdata[g]),
      .rdata (rdata[g]),
      .ack   (ack[g]),
      .busy  (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Call at posedge+1. Issues one transfer, scrambles the inputs right after
  // acceptance, returns read data at ack, ack latency (cycles after the
  // accepting edge, 99 on timeout) and busy-high cycle count. Returns at
  // posedge+1 of the idle cycle following ack.
  task automatic xfer(input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output int lat, output int bcnt);
    req[d] = 1'b1; wen[d] = w; addr[d] = a; wdata[d] = wd;
    @(posedge clk); #1;
    req[d] = 1'b0; wen[d] = ~w; addr[d] = 32'hFFFF_FFFF; wdata[d] = 32'hBAD0_BAD0;
    lat = 1; bcnt = 0;
    while (!ack[d] && lat < 20) begin
      if (busy[d]) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy[d]) bcnt++;
    rd = rdata[d];
    if (!ack[d]) lat = 99;
    @(posedge clk); #1;
    wen[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0;
  endtask

  logic [31:0] rd;
  int lat, bc;

  initial begin
    rst_n = 3'b000; req = 3'b000; wen = 3'b000;
    for (int i = 0; i < 3; i++) begin addr[i] = 32'h0; wdata[i] = 32'h0; end

    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_ack%0d", i),   {31'h0, ack[i]},  32'h0);
      check($sformatf("rst_busy%0d", i),  {31'h0, busy[i]}, 32'h0);
      check($sformatf("rst_rdata%0d", i), rdata[i],         32'h0);
    end
    @(posedge clk); #1;
    rst_n = 3'b111;

    // WAIT=1 write then read of 0x5
    xfer(0, 1'b1, 32'h5, 32'hDEAD_BEEF, rd, lat, bc);
    check("w1_wr_lat",   lat, 2);
    check("w1_wr_busy",  bc,  2);
    check("w1_wr_rdata", rd,  32'h0);
    xfer(0, 1'b0, 32'h5, 32'h0, rd, lat, bc);
    check("w1_rd_lat",  lat, 2);
    check("w1_rd_data", rd,  32'hDEAD_BEEF);
    check("w1_rd_hold", rdata[0], 32'hDEAD_BEEF);
    check("w1_idle_busy", {31'h0, busy[0]}, 32'h0);

    // Aliasing: 0x405 and 0x005 are the same word
    xfer(0, 1'b1, 32'h405, 32'h1234_5678, rd, lat, bc);
    xfer(0, 1'b0, 32'h005, 32'h0, rd, lat, bc);
    check("alias_data", rd, 32'h1234_5678);

    // rdata unchanged by a write ack
    xfer(0, 1'b1, 32'h3, 32'h11, rd, lat, bc);
    xfer(0, 1'b0, 32'h3, 32'h0, rd, lat, bc);
    check("rd3_data", rd, 32'h11);
    xfer(0, 1'b1, 32'h4, 32'h99, rd, lat, bc);
    check("wr4_rdata_hold", rd, 32'h11);
    xfer(0, 1'b0, 32'h4, 32'h0, rd, lat, bc);
    check("rd4_data", rd, 32'h99);

    // WAIT=0: preload, then back-to-back reads with req held high
    xfer(1, 1'b1, 32'h1, 32'h1111_0001, rd, lat, bc);
    check("w0_wr_lat", lat, 1);
    xfer(1, 1'b1, 32'h2, 32'h2222_0002, rd, lat, bc);
    req[1] = 1'b1; wen[1] = 1'b0; addr[1] = 32'h1;
    @(posedge clk); #1;
    check("b2b_c1_ack",   {31'h0, ack[1]}, 32'h1);
    check("b2b_c1_data",  rdata[1], 32'h1111_0001);
    check("b2b_c1_busy",  {31'h0, busy[1]}, 32'h1);
    addr[1] = 32'h2;
    @(posedge clk); #1;
    check("b2b_c2_ack",   {31'h0, ack[1]}, 32'h0);
    check("b2b_c2_busy",  {31'h0, busy[1]}, 32'h0);
    @(posedge clk); #1;
    check("b2b_c3_ack",   {31'h0, ack[1]}, 32'h1);
    check("b2b_c3_data",  rdata[1], 32'h2222_0002);
    req[1] = 1'b0;
    @(posedge clk); #1;
    check("b2b_c4_ack",   {31'h0, ack[1]}, 32'h0);

    // WAIT=3: inputs changed after acceptance do not affect the write
    xfer(2, 1'b1, 32'h7, 32'hCAFE_F00D, rd, lat, bc);
    check("w3_wr_lat",  lat, 4);
    check("w3_wr_busy", bc,  4);
    xfer(2, 1'b0, 32'h7, 32'h0, rd, lat, bc);
    check("w3_rd_data", rd, 32'hCAFE_F00D);

    // WAIT=3: reset during WAITS aborts a pending write
    xfer(2, 1'b1, 32'h9, 32'hAAAA_5555, rd, lat, bc);
    req[2] = 1'b1; wen[2] = 1'b1; addr[2] = 32'h9; wdata[2] = 32'h0;
    @(posedge clk); #1;
    req[2] = 1'b0;
    check("abort_busy_pre", {31'h0, busy[2]}, 32'h1);
    @(posedge clk); #1;
    rst_n[2] = 1'b0;
    #1;
    check("abort_ack",   {31'h0, ack[2]},  32'h0);
    check("abort_busy",  {31'h0, busy[2]}, 32'h0);
    check("abort_rdata", rdata[2],         32'h0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("abort_ack_rst", {31'h0, ack[2]}, 32'h0);
    end
    rst_n[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_ack_post", {31'h0, ack[2] | busy[2]}, 32'h0);
    end
    xfer(2, 1'b0, 32'h9, 32'h0, rd, lat, bc);
    check("abort_rd_lat",  lat, 4);
    check("abort_rd_data", rd,  32'hAAAA_5555);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
